direct_mapped_cache: RTL and testbench
======================================

DIRECT_MAPPED_CACHE -- requirements
Module: direct_mapped_cache

Interface
REQ-001 Parameter INDEX_BITS, default 4, meaning log2 of line count (16 lines of one 32-bit word each).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 core_addr_i in 32 byte address; core_wdata_i in 32 write data; core_we_i in 1 write enable; core_req_i in 1 request; core_be_i in 4 byte enables.
REQ-005 core_rdata_o out 32 read data; core_gnt_o out 1 request accepted; core_rvalid_o out 1 response valid; core_error_o out 1 response error.
REQ-006 mem_addr_o out 32; mem_wdata_o out 32; mem_we_o out 1; mem_req_o out 1; mem_be_o out 4 (memory-side request).
REQ-007 mem_rdata_i in 32; mem_gnt_i in 1; mem_rvalid_i in 1; mem_error_i in 1 (memory-side response).

Function
REQ-008 Address split: offset [1:0], index [INDEX_BITS+1:2], tag [31:INDEX_BITS+2]; each line holds valid bit, tag, 32-bit data.
REQ-009 Both ports use req/gnt/rvalid protocol: transfer accepted in cycle where req and gnt are both high; exactly one rvalid per accepted request, never in the accept cycle.
REQ-010 FSM states IDLE, MEM_REQ, MEM_WAIT, RESP; requests accepted only in IDLE; core_gnt_o = core_req_i while in IDLE, else 0.
REQ-011 On accept the cache SHALL register address, wdata, we, be.
REQ-012 Read hit (valid and tag match): stay in IDLE, core_rvalid_o=1 with line data in the next cycle, no memory traffic; back-to-back hits sustain one per cycle.
REQ-013 Read miss: go to MEM_REQ; drive mem_req_o=1, mem_we_o=0, mem_be_o=4'b1111, mem_addr_o = word-aligned registered address until mem_gnt_i; then MEM_WAIT.
REQ-014 Writes are write-through: MEM_REQ drives mem_we_o=1, mem_addr_o, mem_wdata_o, mem_be_o from registered request until mem_gnt_i; then MEM_WAIT.
REQ-015 Write cache update at accept: hit -> merge enabled bytes into line; miss with be=4'b1111 -> allocate (valid=1, new tag, wdata); miss with partial be -> no allocation.
REQ-016 MEM_WAIT: on mem_rvalid_i go to RESP; for read miss without mem_error_i fill line (valid, tag, mem_rdata_i) and capture data.
REQ-017 RESP: core_rvalid_o=1 for one cycle with captured data (reads) and core_error_o=mem_error_i captured; return to IDLE.
REQ-018 mem_error_i on a read miss: no fill, line unchanged; error forwarded per REQ-017; core_error_o=0 at all other times.
REQ-019 mem_req_o SHALL drop in the cycle after mem_gnt_i; at most one memory transaction outstanding.
REQ-020 core_rdata_o is undefined-but-stable (hold last value) when core_rvalid_o=0; write responses return rdata unchanged.
REQ-021 Core inputs ignored while not in IDLE; core_req_i deassertion after grant does not cancel the transaction.

Reset
REQ-022 reset SHALL clear all valid bits, force IDLE, and drive core_gnt_o=0 (when req low), core_rvalid_o=0, core_error_o=0, mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wdata_o=0, core_rdata_o=0.
REQ-023 reset mid-transaction SHALL abandon it; no rvalid is issued for it; tag/data arrays need not be cleared.

Structure
REQ-024 Shared package cache_pkg SHALL hold INDEX_BITS default, derived TAG_BITS, and the FSM state enum.
REQ-025 One sub-module cache_storage SHALL implement valid/tag/data arrays with byte-enable write port and combinational read port; FSM and hit logic stay in the top.

Verification (bench: cache memory side via ram_mux port1 to sp_ram_wrap, RAM_SIZE 32, DATA_WIDTH 32; memory grants same cycle, rvalid next cycle)
REQ-026 Reset 2 cycles then idle -> all outputs at reset values, no mem_req_o.
REQ-027 Write 0x1234ABCD to 0x0010_0000, be=1111, one-cycle req -> gnt same cycle, one mem write of 0x1234ABCD, core_rvalid_o once, core_error_o=0.
REQ-028 Then read 0x0010_0000 -> hit: rvalid next cycle, rdata=0x1234ABCD, mem_req_o stays 0.
REQ-029 Read 0x0020_0000 (same index, other tag) -> miss: one mem read with be=1111, line refilled, rvalid with memory value; subsequent read of 0x0010_0000 misses.
REQ-030 Write 0x0000_00EE to cached 0x0010_0000 with be=0001 -> memory and line updated; read returns 0x1234ABEE.
REQ-031 Read miss with mem_error_i=1 at mem_rvalid_i -> core_error_o=1 with core_rvalid_o; repeat read misses again.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped cache.
//   DEFAULT_INDEX_BITS : log2 of the line count (one 32-bit word per line)
//   DEFAULT_TAG_BITS   : tag width derived from DEFAULT_INDEX_BITS
//   tag_bits()         : tag width for any index width
//   cache_state_e      : controller FSM state encoding
//   merge_bytes()      : byte-enable merge of a new word into an old word
package cache_pkg;

    localparam int ADDR_BITS          = 32;
    localparam int OFFSET_BITS        = 2;
    localparam int DEFAULT_INDEX_BITS = 4;

    function automatic int tag_bits(input int index_bits);
        return ADDR_BITS - index_bits - OFFSET_BITS;
    endfunction

    localparam int DEFAULT_TAG_BITS = ADDR_BITS - DEFAULT_INDEX_BITS - OFFSET_BITS;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_REQ  = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_RESP     = 2'd3
    } cache_state_e;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/cache_storage.sv
// Line storage for the direct-mapped cache: valid bits, tags and one data
// word per line.
//   clk, reset     : clock, synchronous active-high reset (clears valid bits)
//   rd_idx         : combinational read index
//   rd_valid/tag/data : contents of line rd_idx
//   wr_en          : write strobe; sets the line valid and replaces the tag
//   wr_idx/tag/data/be : write port; only bytes with wr_be set are replaced
module cache_storage
    import cache_pkg::*;
#(
    parameter int INDEX_BITS = DEFAULT_INDEX_BITS,
    parameter int TAG_W      = DEFAULT_TAG_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [31:0]           rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [31:0]           wr_data,
    input  logic [3:0]            wr_be
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    // Only the valid bits are reset; tag/data contents are don't-care while
    // the line is invalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= merge_bytes(data_q[wr_idx], wr_data, wr_be);
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/direct_mapped_cache.sv
// Direct-mapped, write-through, one-word-per-line cache between a core port
// and a memory port, both using req/gnt/rvalid.
//
// Handshake (both ports): a transfer is accepted in the cycle where req and
// gnt are both high; each accepted request gets exactly one rvalid cycle,
// never in the accept cycle. The cache accepts core requests only in IDLE
// and keeps at most one memory transaction outstanding.
//
//   clk, reset          : clock, synchronous active-high reset
//   core_*_i / core_*_o : core-side request / response
//   mem_*_o / mem_*_i   : memory-side request / response
//   dbg_state           : current controller state
//
// Read hits answer in the cycle after accept without memory traffic. Read
// misses fetch the word and refill the line (unless memory reports an
// error). Writes always go to memory; the line is updated at accept on a
// hit (byte merge) or on a full-word miss (allocate). Partial-word write
// misses do not allocate.
module direct_mapped_cache
    import cache_pkg::*;
#(
    parameter int INDEX_BITS = DEFAULT_INDEX_BITS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  core_addr_i,
    input  logic [31:0]  core_wdata_i,
    input  logic         core_we_i,
    input  logic         core_req_i,
    input  logic [3:0]   core_be_i,
    output logic [31:0]  core_rdata_o,
    output logic         core_gnt_o,
    output logic         core_rvalid_o,
    output logic         core_error_o,
    output logic [31:0]  mem_addr_o,
    output logic [31:0]  mem_wdata_o,
    output logic         mem_we_o,
    output logic         mem_req_o,
    output logic [3:0]   mem_be_o,
    input  logic [31:0]  mem_rdata_i,
    input  logic         mem_gnt_i,
    input  logic         mem_rvalid_i,
    input  logic         mem_error_i,
    output cache_state_e dbg_state
);

    localparam int TAG_W = tag_bits(INDEX_BITS);

    cache_state_e state;

    // Registered word address and direction of the accepted request.
    logic [29:0] req_word;
    logic        req_we;

    logic [INDEX_BITS-1:0] in_idx;
    logic [TAG_W-1:0]      in_tag;
    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_W-1:0]      req_tag;

    logic                  line_valid;
    logic [TAG_W-1:0]      line_tag;
    logic [31:0]           line_data;
    logic                  hit;
    logic                  accept;

    logic                  wr_en;
    logic [INDEX_BITS-1:0] wr_idx;
    logic [TAG_W-1:0]      wr_tag;
    logic [31:0]           wr_data;
    logic [3:0]            wr_be;

    assign in_idx  = core_addr_i[INDEX_BITS+1:2];
    assign in_tag  = core_addr_i[31:INDEX_BITS+2];
    assign req_idx = req_word[INDEX_BITS-1:0];
    assign req_tag = req_word[29:INDEX_BITS];

    assign core_gnt_o = (state == ST_IDLE) && core_req_i;
    assign accept     = core_gnt_o;
    assign hit        = line_valid && (line_tag == in_tag);
    assign dbg_state  = state;

    // Storage write port: write updates happen at accept, read-miss fills
    // happen when the memory response arrives. The two never coincide
    // because accepts only occur in IDLE.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = in_idx;
        wr_tag  = in_tag;
        wr_data = core_wdata_i;
        wr_be   = core_be_i;
        if (!reset) begin
            if (accept && core_we_i) begin
                wr_en = hit || (core_be_i == 4'b1111);
            end else if ((state == ST_MEM_WAIT) && mem_rvalid_i && !req_we && !mem_error_i) begin
                wr_en   = 1'b1;
                wr_idx  = req_idx;
                wr_tag  = req_tag;
                wr_data = mem_rdata_i;
                wr_be   = 4'b1111;
            end
        end
    end

    cache_storage #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W)
    ) u_storage (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (in_idx),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_tag   (wr_tag),
        .wr_data  (wr_data),
        .wr_be    (wr_be)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            req_word      <= '0;
            req_we        <= 1'b0;
            core_rdata_o  <= '0;
            core_rvalid_o <= 1'b0;
            core_error_o  <= 1'b0;
            mem_req_o     <= 1'b0;
            mem_we_o      <= 1'b0;
            mem_be_o      <= '0;
            mem_addr_o    <= '0;
            mem_wdata_o   <= '0;
        end else begin
            // Response strobes are single-cycle pulses.
            core_rvalid_o <= 1'b0;
            core_error_o  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (core_req_i) begin
                        req_word <= core_addr_i[31:2];
                        req_we   <= core_we_i;
                        if (!core_we_i && hit) begin
                            core_rvalid_o <= 1'b1;
                            core_rdata_o  <= line_data;
                        end else begin
                            state       <= ST_MEM_REQ;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= core_we_i;
                            mem_wdata_o <= core_wdata_i;
                            // Reads fetch the whole aligned word; writes pass
                            // the core's address and byte enables through.
                            mem_addr_o  <= core_we_i ? core_addr_i : {core_addr_i[31:2], 2'b00};
                            mem_be_o    <= core_we_i ? core_be_i : 4'b1111;
                        end
                    end
                end
                ST_MEM_REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        state     <= ST_MEM_WAIT;
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_rvalid_i) begin
                        state         <= ST_RESP;
                        core_rvalid_o <= 1'b1;
                        core_error_o  <= mem_error_i;
                        // Write responses and failed reads leave rdata as is.
                        if (!req_we && !mem_error_i) begin
                            core_rdata_o <= mem_rdata_i;
                        end
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_direct_mapped_cache.sv
module tb_direct_mapped_cache;
    import cache_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [31:0]  core_addr_i = '0;
    logic [31:0]  core_wdata_i = '0;
    logic         core_we_i = 1'b0;
    logic         core_req_i = 1'b0;
    logic [3:0]   core_be_i = '0;
    logic [31:0]  core_rdata_o;
    logic         core_gnt_o;
    logic         core_rvalid_o;
    logic         core_error_o;
    logic [31:0]  mem_addr_o;
    logic [31:0]  mem_wdata_o;
    logic         mem_we_o;
    logic         mem_req_o;
    logic [3:0]   mem_be_o;
    logic [31:0]  mem_rdata_i = '0;
    logic         mem_gnt_i;
    logic         mem_rvalid_i = 1'b0;
    logic         mem_error_i = 1'b0;
    cache_state_e dbg_state;

    direct_mapped_cache #(.INDEX_BITS(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .core_addr_i   (core_addr_i),
        .core_wdata_i  (core_wdata_i),
        .core_we_i     (core_we_i),
        .core_req_i    (core_req_i),
        .core_be_i     (core_be_i),
        .core_rdata_o  (core_rdata_o),
        .core_gnt_o    (core_gnt_o),
        .core_rvalid_o (core_rvalid_o),
        .core_error_o  (core_error_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_we_o      (mem_we_o),
        .mem_req_o     (mem_req_o),
        .mem_be_o      (mem_be_o),
        .mem_rdata_i   (mem_rdata_i),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_error_i   (mem_error_i),
        .dbg_state     (dbg_state)
    );

    // ---------------- memory model ----------------
    // Grants in the request cycle, answers in the next cycle.
    logic [31:0] ram [logic [31:0]];
    int          mem_rd_cnt = 0;
    int          mem_wr_cnt = 0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_wdata = '0;
    logic [3:0]  last_be = '0;
    logic        last_we = 1'b0;
    logic        err_inject = 1'b0;
    logic [31:0] m_key, m_old, m_new;

    assign mem_gnt_i = mem_req_o;

    always @(posedge clk) begin
        mem_rvalid_i <= 1'b0;
        mem_error_i  <= 1'b0;
        if (mem_req_o === 1'b1 && mem_gnt_i === 1'b1) begin
            m_key = {mem_addr_o[31:2], 2'b00};
            m_old = ram.exists(m_key) ? ram[m_key] : 32'h0;
            last_addr  = mem_addr_o;
            last_wdata = mem_wdata_o;
            last_be    = mem_be_o;
            last_we    = mem_we_o;
            if (mem_we_o) begin
                m_new = m_old;
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) m_new[8*b +: 8] = mem_wdata_o[8*b +: 8];
                ram[m_key] = m_new;
                mem_wr_cnt++;
                mem_rdata_i <= 32'h0;
            end else begin
                mem_rd_cnt++;
                mem_rdata_i <= m_old;
            end
            mem_rvalid_i <= 1'b1;
            mem_error_i  <= err_inject;
        end
    end

    // ---------------- scoreboard / checks ----------------
    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        err;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be, input logic err, input logic [31:0] exp_rdata,
                                input logic exp_err, input int exp_lat, input int exp_rd, input int exp_wr);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.be = be; v.err = err;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
        v.exp_rd = exp_rd; v.exp_wr = exp_wr;
        return v;
    endfunction

    // ---------------- driver ----------------
    task automatic run_vec(input int n, input vec_t v);
        int  rd0, wr0, lat;
        bit  seen;
        string p;
        p = $sformatf("v%0d", n);
        rd0 = mem_rd_cnt;
        wr0 = mem_wr_cnt;
        @(negedge clk);
        core_req_i   = 1'b1;
        core_we_i    = v.we;
        core_addr_i  = v.addr;
        core_wdata_i = v.wdata;
        core_be_i    = v.be;
        err_inject   = v.err;
        #1;
        check({p, "_gnt"}, {31'b0, core_gnt_o}, 32'd1);
        check({p, "_no_rvalid_at_accept"}, {31'b0, core_rvalid_o}, 32'd0);
        @(posedge clk);
        #1;
        // Core inputs change after grant; the transaction must not notice.
        core_req_i   = 1'b0;
        core_we_i    = 1'b0;
        core_addr_i  = 32'hDEAD_BEEC;
        core_wdata_i = 32'hFFFF_FFFF;
        core_be_i    = 4'b0000;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (core_rvalid_o === 1'b1) seen = 1'b1;
        end
        check({p, "_rvalid_seen"}, {31'b0, seen}, 32'd1);
        if (seen) begin
            check({p, "_latency"}, lat, v.exp_lat);
            check({p, "_error"}, {31'b0, core_error_o}, {31'b0, v.exp_err});
            if (!v.exp_err) check({p, "_rdata"}, core_rdata_o, v.exp_rdata);
            check({p, "_mem_reads"}, mem_rd_cnt - rd0, v.exp_rd);
            check({p, "_mem_writes"}, mem_wr_cnt - wr0, v.exp_wr);
            if (v.exp_rd + v.exp_wr > 0) begin
                check({p, "_mem_addr"}, last_addr, v.addr);
                check({p, "_mem_we"}, {31'b0, last_we}, {31'b0, v.we});
                check({p, "_mem_be"}, {28'b0, last_be}, {28'b0, (v.we ? v.be : 4'b1111)});
                if (v.we) check({p, "_mem_wdata"}, last_wdata, v.wdata);
            end
        end
        err_inject = 1'b0;
        @(negedge clk);
        check({p, "_single_rvalid"}, {31'b0, core_rvalid_o}, 32'd0);
        check({p, "_mem_req_idle"}, {31'b0, mem_req_o}, 32'd0);
    endtask

    // ---------------- test ----------------
    initial begin
        int rd0, rv_cnt;

        ram[32'h0020_0000] = 32'hCAFE_F00D;
        ram[32'h0030_0008] = 32'h55AA_55AA;
        ram[32'h0040_0004] = 32'h1111_2222;

        //            we    addr            wdata          be       err   exp_rdata      eerr lat rd wr
        vecs.push_back(mk(1'b1, 32'h0010_0000, 32'h1234_ABCD, 4'b1111, 1'b0, 32'h0000_0000, 1'b0, 3, 0, 1));
        vecs.push_back(mk(1'b0, 32'h0010_0000, 32'h0,         4'b1111, 1'b0, 32'h1234_ABCD, 1'b0, 1, 0, 0));
        vecs.push_back(mk(1'b0, 32'h0020_0000, 32'h0,         4'b1111, 1'b0, 32'hCAFE_F00D, 1'b0, 3, 1, 0));
        vecs.push_back(mk(1'b0, 32'h0020_0000, 32'h0,         4'b1111, 1'b0, 32'hCAFE_F00D, 1'b0, 1, 0, 0));
        vecs.push_back(mk(1'b0, 32'h0010_0000, 32'h0,         4'b1111, 1'b0, 32'h1234_ABCD, 1'b0, 3, 1, 0));
        vecs.push_back(mk(1'b1, 32'h0010_0000, 32'h0000_00EE, 4'b0001, 1'b0, 32'h1234_ABCD, 1'b0, 3, 0, 1));
        vecs.push_back(mk(1'b0, 32'h0010_0000, 32'h0,         4'b1111, 1'b0, 32'h1234_ABEE, 1'b0, 1, 0, 0));
        vecs.push_back(mk(1'b0, 32'h0030_0008, 32'h0,         4'b1111, 1'b1, 32'h0,         1'b1, 3, 1, 0));
        vecs.push_back(mk(1'b0, 32'h0030_0008, 32'h0,         4'b1111, 1'b0, 32'h55AA_55AA, 1'b0, 3, 1, 0));
        vecs.push_back(mk(1'b0, 32'h0030_0008, 32'h0,         4'b1111, 1'b0, 32'h55AA_55AA, 1'b0, 1, 0, 0));
        vecs.push_back(mk(1'b1, 32'h0040_0004, 32'hBEEF_0000, 4'b1100, 1'b0, 32'h55AA_55AA, 1'b0, 3, 0, 1));
        vecs.push_back(mk(1'b0, 32'h0040_0004, 32'h0,         4'b1111, 1'b0, 32'hBEEF_2222, 1'b0, 3, 1, 0));
        vecs.push_back(mk(1'b1, 32'h0050_0004, 32'hA5A5_A5A5, 4'b1111, 1'b0, 32'hBEEF_2222, 1'b0, 3, 0, 1));
        vecs.push_back(mk(1'b0, 32'h0050_0004, 32'h0,         4'b1111, 1'b0, 32'hA5A5_A5A5, 1'b0, 1, 0, 0));
        vecs.push_back(mk(1'b0, 32'h0040_0004, 32'h0,         4'b1111, 1'b0, 32'hBEEF_2222, 1'b0, 3, 1, 0));

        // Reset for two cycles, then idle.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("idle_mem_req", {31'b0, mem_req_o}, 32'd0);
            check("idle_rvalid", {31'b0, core_rvalid_o}, 32'd0);
        end
        check("rst_gnt", {31'b0, core_gnt_o}, 32'd0);
        check("rst_error", {31'b0, core_error_o}, 32'd0);
        check("rst_rdata", core_rdata_o, 32'd0);
        check("rst_mem_we", {31'b0, mem_we_o}, 32'd0);
        check("rst_mem_be", {28'b0, mem_be_o}, 32'd0);
        check("rst_mem_addr", mem_addr_o, 32'd0);
        check("rst_mem_wdata", mem_wdata_o, 32'd0);
        check("rst_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});

        for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

        // Back-to-back read hits: one response per cycle, no memory traffic.
        rd0 = mem_rd_cnt;
        exp_q.push_back(32'h1234_ABEE);
        exp_q.push_back(32'hBEEF_2222);
        exp_q.push_back(32'h55AA_55AA);
        @(negedge clk);
        core_req_i = 1'b1; core_we_i = 1'b0; core_be_i = 4'b1111;
        core_addr_i = 32'h0010_0000;
        @(posedge clk); #1 core_addr_i = 32'h0040_0004;
        @(negedge clk);
        check("b2b_gnt1", {31'b0, core_gnt_o}, 32'd1);
        check("b2b_rvalid1", {31'b0, core_rvalid_o}, 32'd1);
        check("b2b_rdata1", core_rdata_o, exp_q.pop_front());
        @(posedge clk); #1 core_addr_i = 32'h0030_0008;
        @(negedge clk);
        check("b2b_rvalid2", {31'b0, core_rvalid_o}, 32'd1);
        check("b2b_rdata2", core_rdata_o, exp_q.pop_front());
        @(posedge clk); #1 core_req_i = 1'b0;
        @(negedge clk);
        check("b2b_rvalid3", {31'b0, core_rvalid_o}, 32'd1);
        check("b2b_rdata3", core_rdata_o, exp_q.pop_front());
        @(negedge clk);
        check("b2b_end_rvalid", {31'b0, core_rvalid_o}, 32'd0);
        check("b2b_mem_reads", mem_rd_cnt - rd0, 32'd0);

        // Miss interrupted by reset: no grant outside IDLE, no response after.
        @(negedge clk);
        core_req_i = 1'b1; core_we_i = 1'b0; core_be_i = 4'b1111;
        core_addr_i = 32'h0060_0000;
        @(posedge clk);
        @(negedge clk);
        check("busy_gnt", {31'b0, core_gnt_o}, 32'd0);
        check("busy_mem_req", {31'b0, mem_req_o}, 32'd1);
        check("busy_state", {30'b0, dbg_state}, {30'b0, ST_MEM_REQ});
        reset = 1'b1;
        core_req_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        rv_cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (core_rvalid_o !== 1'b0) rv_cnt++;
        end
        check("abandon_no_rvalid", rv_cnt, 32'd0);
        check("abandon_mem_req", {31'b0, mem_req_o}, 32'd0);
        // Valid bits were cleared, so a previously cached address misses.
        run_vec(100, mk(1'b0, 32'h0010_0000, 32'h0, 4'b1111, 1'b0, 32'h1234_ABEE, 1'b0, 3, 1, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the bench always ends.
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: got running expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
